// File: rtl/draw_layer_scheduler.sv
// Frame-synchronous priority scheduler for the VGA drawing layers. It picks the highest-priority
// requesting layer per pixel through a 2-stage pipeline and counts per-frame layer overlaps.
module draw_layer_scheduler #(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned RGB_W      = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
    parameter logic [RGB_W-1:0] BG_COLOR    = 8'h00,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       drawReq,
    input  logic [NUM_LAYERS*RGB_W-1:0] rgbIn,
    input  logic                        cfgWr,
    input  logic [LW-1:0]               cfgSlot,
    input  logic [LW-1:0]               cfgLayer,
    input  logic                        cfgEn,
    output logic [RGB_W-1:0]            RGBOut,
    output logic [LW-1:0]               winnerIdx,
    output logic                        winnerValid,
    output logic [CNT_W-1:0]            overlapCount
);

    typedef enum logic {StWaitSof, StActive} state_e;

    state_e state_q, state_d;

    logic [LW-1:0]         shadow_layer_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] shadow_en_q;
    logic [LW-1:0]         active_layer_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] active_en_q;

    logic [RGB_W-1:0]      layer_rgb   [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] layer_req;
    logic [LW-1:0]         frame_layer [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] frame_en;
    logic [NUM_LAYERS-1:0] slot_req;
    logic [RGB_W-1:0]      slot_rgb    [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] layer_hit;
    logic                  pix_active;
    logic                  overlap;

    logic [NUM_LAYERS-1:0] req_q;
    logic [RGB_W-1:0]      rgb_q   [NUM_LAYERS];
    logic [LW-1:0]         layer_q [NUM_LAYERS];

    logic [RGB_W-1:0]      win_rgb;
    logic [LW-1:0]         win_idx;
    logic                  win_valid;

    logic [CNT_W-1:0]      run_q, run_d;

    always_comb begin
        state_d = state_q;
        if (state_q == StWaitSof && startOfFrame) state_d = StActive;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= StWaitSof;
        else         state_q <= state_d;
    end

    // The active table captures the shadow before any coincident write lands.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_layer_q[i] <= LW'(i);
                active_layer_q[i] <= LW'(i);
            end
            shadow_en_q <= '1;
            active_en_q <= '1;
        end else begin
            if (cfgWr) begin
                shadow_layer_q[cfgSlot] <= cfgLayer;
                shadow_en_q[cfgSlot]    <= cfgEn;
            end
            if (startOfFrame) begin
                active_layer_q <= shadow_layer_q;
                active_en_q    <= shadow_en_q;
            end
        end
    end

    // The first pixel of a frame already uses the table being loaded, so a whole frame sees one table.
    always_comb begin
        pix_active = (state_q == StActive) || startOfFrame;
        layer_hit  = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            layer_rgb[l] = rgbIn[l*RGB_W +: RGB_W];
            layer_req[l] = drawReq[l] && (layer_rgb[l] != TRANSPARENT);
        end
        for (int s = 0; s < NUM_LAYERS; s++) begin
            frame_layer[s] = startOfFrame ? shadow_layer_q[s] : active_layer_q[s];
            frame_en[s]    = startOfFrame ? shadow_en_q[s] : active_en_q[s];
            slot_req[s]    = pix_active && frame_en[s] && layer_req[frame_layer[s]];
            slot_rgb[s]    = layer_rgb[frame_layer[s]];
            if (slot_req[s]) layer_hit[frame_layer[s]] = 1'b1;
        end
        overlap = $countones(layer_hit) >= 2;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            req_q <= '0;
            for (int s = 0; s < NUM_LAYERS; s++) begin
                rgb_q[s]   <= BG_COLOR;
                layer_q[s] <= '0;
            end
        end else begin
            req_q   <= slot_req;
            rgb_q   <= slot_rgb;
            layer_q <= frame_layer;
        end
    end

    always_comb begin
        win_rgb   = BG_COLOR;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
            if (req_q[s]) begin
                win_rgb   = rgb_q[s];
                win_idx   = layer_q[s];
                win_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut      <= BG_COLOR;
            winnerIdx   <= '0;
            winnerValid <= 1'b0;
        end else begin
            RGBOut      <= win_rgb;
            winnerIdx   <= win_idx;
            winnerValid <= win_valid;
        end
    end

    always_comb begin
        run_d = run_q;
        if (startOfFrame) begin
            run_d = overlap ? CNT_W'(1) : '0;
        end else if (pix_active && overlap && run_q != {CNT_W{1'b1}}) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            run_q        <= '0;
            overlapCount <= '0;
        end else begin
            run_q <= run_d;
            if (startOfFrame) overlapCount <= run_q;
        end
    end

endmodule
